// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI-over-APB byte sequencer: controller register
// map, STATUS bit positions and the sequencer state encoding.
package spi_apb_pkg;

  localparam logic [6:0] REG_CTRL   = 7'h00;
  localparam logic [6:0] REG_RXDATA = 7'h08;
  localparam logic [6:0] REG_TXDATA = 7'h0C;
  localparam logic [6:0] REG_STATUS = 7'h20;
  localparam logic [6:0] REG_SSEL   = 7'h24;

  // STATUS bit that reads 1 while the receive FIFO holds no byte.
  localparam int STATUS_RX_EMPTY_BIT = 2;

  typedef enum logic [2:0] {
    ST_INIT_CTRL,
    ST_INIT_SSEL,
    ST_IDLE,
    ST_WR_TX,
    ST_POLL,
    ST_RD_RX,
    ST_RESP,
    ST_ERR
  } state_e;

endpackage

// File: rtl/apb_master_if.sv
// Single-outstanding APB master. A start pulse launches SETUP on the next
// cycle; ACCESS is held until pready. A start seen in the completing cycle
// chains straight into the next SETUP so PSEL stays high back-to-back.
module apb_master_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [6:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [6:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;

  // Completion is only meaningful in ACCESS; completer outputs pass through.
  assign done   = psel_q & penable_q & pready;
  assign rdata  = prdata;
  assign slverr = pslverr;

  // Next bus phase: new SETUP, SETUP->ACCESS, or release after completion.
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start && (!psel_q || done)) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = write;
      paddr_d   = addr;
      pwdata_d  = wdata;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // Bus request registers; reset drops the bus even mid-access.
  always_ff @(posedge clk) begin
    if (rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: rtl/spi_apb_sequencer.sv
// Byte-transfer sequencer: initialises an APB SPI controller, then for each
// accepted byte writes TXDATA, polls STATUS until RX is non-empty (bounded by
// POLL_LIMIT) and returns the RXDATA byte on a one-cycle rsp_valid pulse.
// Request handshake: a byte is taken on a cycle where req_valid && req_ready;
// req_valid without req_ready is ignored and never buffered.
module spi_apb_sequencer
  import spi_apb_pkg::*;
#(
  parameter int          POLL_LIMIT = 1023,
  parameter logic [7:0]  SSEL_MASK  = 8'h01,
  parameter logic [31:0] CTRL_INIT  = 32'h0000_0003
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        err,
  output logic [6:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output state_e      dbg_state
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

  state_e         state_q, state_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d, poll_next;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           err_q, err_d;

  logic        acc_start, acc_write, acc_done, acc_slverr;
  logic [6:0]  acc_addr;
  logic [31:0] acc_wdata, acc_rdata;
  logic        unused_rdata;

  assign unused_rdata = ^acc_rdata[31:8];
  assign poll_next    = poll_cnt_q + PCW'(1);

  apb_master_if u_apb (
    .clk     (PCLK),
    .rst     (PRESET),
    .start   (acc_start),
    .write   (acc_write),
    .addr    (acc_addr),
    .wdata   (acc_wdata),
    .done    (acc_done),
    .rdata   (acc_rdata),
    .slverr  (acc_slverr),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .prdata  (PRDATA),
    .pready  (PREADY),
    .pslverr (PSLVERR)
  );

  // Next state; each access is launched in the cycle its predecessor completes.
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    rsp_data_d = rsp_data_q;
    acc_start  = 1'b0;
    acc_write  = 1'b0;
    acc_addr   = REG_CTRL;
    acc_wdata  = '0;
    case (state_q)
      ST_INIT_CTRL: begin
        if (!PSEL) begin
          acc_start = 1'b1;
          acc_write = 1'b1;
          acc_addr  = REG_CTRL;
          acc_wdata = CTRL_INIT;
        end else if (acc_done) begin
          if (acc_slverr) begin
            state_d = ST_ERR;
          end else begin
            state_d   = ST_INIT_SSEL;
            acc_start = 1'b1;
            acc_write = 1'b1;
            acc_addr  = REG_SSEL;
            acc_wdata = {24'h0, SSEL_MASK};
          end
        end
      end
      ST_INIT_SSEL: begin
        if (acc_done) state_d = acc_slverr ? ST_ERR : ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d    = ST_WR_TX;
          poll_cnt_d = '0;
          acc_start  = 1'b1;
          acc_write  = 1'b1;
          acc_addr   = REG_TXDATA;
          acc_wdata  = {24'h0, req_data};
        end
      end
      ST_WR_TX: begin
        if (acc_done) begin
          if (acc_slverr) begin
            state_d = ST_ERR;
          end else begin
            state_d   = ST_POLL;
            acc_start = 1'b1;
            acc_addr  = REG_STATUS;
          end
        end
      end
      ST_POLL: begin
        if (acc_done) begin
          if (acc_slverr) begin
            state_d = ST_ERR;
          end else if (!acc_rdata[STATUS_RX_EMPTY_BIT]) begin
            state_d   = ST_RD_RX;
            acc_start = 1'b1;
            acc_addr  = REG_RXDATA;
          end else begin
            poll_cnt_d = poll_next;
            if (poll_next == POLL_MAX) begin
              state_d = ST_ERR;
            end else begin
              acc_start = 1'b1;
              acc_addr  = REG_STATUS;
            end
          end
        end
      end
      ST_RD_RX: begin
        if (acc_done) begin
          if (acc_slverr) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_RESP;
            rsp_data_d = acc_rdata[7:0];
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    err_d       = err_q | (state_d == ST_ERR);
  end

  // State and registered user-side outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_INIT_CTRL;
      poll_cnt_q  <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer: behavioural APB completer with configurable
// wait states, RX-empty poll count and error injection; expected bus traffic,
// latency and response bytes are derived from the transfer rules.
module tb_spi_apb_sequencer;

  localparam int LIMIT = 4;
  localparam logic [6:0] A_CTRL = 7'h00, A_RX = 7'h08, A_TX = 7'h0C;
  localparam logic [6:0] A_STAT = 7'h20, A_SSEL = 7'h24;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready, rsp_valid, err;
  logic [7:0]  rsp_data;
  logic [6:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  spi_apb_pkg::state_e dbg_state;

  spi_apb_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // Clock
  always #5 PCLK = ~PCLK;

  // Completer configuration (written by the test sequence)
  int          cfg_wait = 0;
  int          cfg_empty = 0;
  logic        cfg_err_tx = 1'b0;
  logic [7:0]  cfg_rx = 8'h00;
  logic [31:0] cfg_stat_hi = 32'h0;
  logic [31:0] cfg_rx_hi = 32'h0;
  int          stat_base = 0;

  // Completer observations (written only by the completer)
  int          stat_total = 0;
  int          prot_errs = 0;
  logic [39:0] log_q[$];
  int          phase = 0;   // 0 idle, 1 setup, 2 waiting access, 3 completed
  int          wait_ctr = 0;
  logic [39:0] setup_sig = '0;

  // Scoreboard
  logic [39:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  // Behavioural APB completer and protocol monitor, updated away from posedge.
  always @(negedge PCLK) begin
    if (PRESET) begin
      phase    = 0;
      wait_ctr = 0;
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      PRDATA   = $urandom;
    end else begin
      PREADY  = 1'($urandom_range(0, 1));
      PSLVERR = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      if (PENABLE && !PSEL) prot_errs++;
      if (PSEL && !PENABLE) begin
        if (phase == 1 || phase == 2) prot_errs++;
        setup_sig = {PWRITE, PADDR, PWDATA};
        wait_ctr  = 0;
        phase     = 1;
      end else if (PSEL && PENABLE) begin
        if (!(phase == 1 || phase == 2)) prot_errs++;
        if ({PWRITE, PADDR, PWDATA} !== setup_sig) prot_errs++;
        if (wait_ctr < cfg_wait) begin
          wait_ctr++;
          PREADY = 1'b0;
          phase  = 2;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = cfg_err_tx && PWRITE && (PADDR == A_TX);
          if (!PWRITE && PADDR == A_STAT) begin
            PRDATA = (stat_total - stat_base < cfg_empty) ? (cfg_stat_hi | 32'h4) : cfg_stat_hi;
            stat_total++;
          end else if (!PWRITE && PADDR == A_RX) begin
            PRDATA = {cfg_rx_hi[31:8], cfg_rx};
          end
          log_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
          phase = 3;
        end
      end else begin
        if (phase == 1 || phase == 2) prot_errs++;
        phase = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input int start);
    check("bus_access_count", 40'(log_q.size() - start), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i < log_q.size())
        check($sformatf("bus_access[%0d]", i), log_q[start + i], exp_q[i]);
    end
  endtask

  // Reset (possibly mid-access), check reset values, then the init writes.
  task automatic do_reset();
    int cyc;
    int start;
    int pbase;
    PRESET    = 1'b1;
    req_valid = 1'b0;
    @(negedge PCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, spi_apb_pkg::ST_INIT_CTRL);
    repeat (2) @(negedge PCLK);
    cfg_wait   = $urandom_range(0, 2);
    cfg_err_tx = 1'b0;
    start      = log_q.size();
    pbase      = prot_errs;
    exp_q.delete();
    exp_q.push_back({1'b1, A_CTRL, 32'h0000_0003});
    exp_q.push_back({1'b1, A_SSEL, 32'h0000_0001});
    PRESET = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    check("ready_after_init", req_ready, 1);
    check("err_after_init", err, 0);
    check_log(start);
    check("protocol_init", 40'(prot_errs - pbase), 0);
  endtask

  // One byte transfer with expected traffic, latency and outcome from the rules.
  task automatic run_xfer(input logic [7:0] tx, input int n_empty, input int n_wait,
                          input logic [7:0] rx, input logic noise, input logic err_tx);
    int   lat;
    int   cyc;
    int   start;
    int   pbase;
    int   exp_lat;
    logic exp_err;
    cfg_empty   = n_empty;
    cfg_wait    = n_wait;
    cfg_rx      = rx;
    cfg_err_tx  = err_tx;
    cfg_stat_hi = $urandom & ~32'h4;
    cfg_rx_hi   = $urandom;
    stat_base   = stat_total;
    pbase       = prot_errs;
    start       = log_q.size();
    exp_err     = err_tx || (n_empty >= LIMIT);
    exp_lat     = (n_empty + 3) * (n_wait + 2) + 1;
    exp_q.delete();
    exp_q.push_back({1'b1, A_TX, 24'h0, tx});
    if (!err_tx) begin
      for (int i = 0; i < LIMIT; i++) begin
        if (i < n_empty) begin
          exp_q.push_back({1'b0, A_STAT, cfg_stat_hi | 32'h4});
        end else begin
          exp_q.push_back({1'b0, A_STAT, cfg_stat_hi});
          exp_q.push_back({1'b0, A_RX, cfg_rx_hi[31:8], rx});
          break;
        end
      end
    end
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_data  = tx;
    @(negedge PCLK);
    req_valid = noise;
    req_data  = ~tx;
    lat = 1;
    while (!rsp_valid && !err && lat < 400) begin
      @(negedge PCLK);
      lat++;
    end
    req_valid = 1'b0;
    if (exp_err) begin
      check("err_set", err, 1);
      check("no_rsp_on_err", rsp_valid, 0);
      repeat (4) @(negedge PCLK);
      check("err_sticky", err, 1);
      check("ready_low_in_err", req_ready, 0);
      check("bus_idle_in_err", PSEL, 0);
    end else begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, rx);
      check("latency", 40'(lat), 40'(exp_lat));
      check("no_err", err, 0);
      @(negedge PCLK);
      check("rsp_pulse_one_cycle", rsp_valid, 0);
      check("rsp_data_hold", rsp_data, rx);
    end
    check_log(start);
    check("protocol_xfer", 40'(prot_errs - pbase), 0);
  endtask

  // Test sequence
  initial begin
    int cyc;
    @(negedge PCLK);
    do_reset();

    // Minimum-latency transfer, zero wait states, first poll non-empty.
    run_xfer(8'hA5, 0, 0, 8'h5A, 1'b0, 1'b0);

    // Three empty polls, two wait states per access, request noise held high.
    run_xfer(8'($urandom), 3, 2, 8'($urandom), 1'b1, 1'b0);

    // Randomised transfers.
    for (int k = 0; k < 8; k++)
      run_xfer(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
               8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Poll timeout: STATUS never non-empty.
    run_xfer(8'($urandom), 10, $urandom_range(0, 1), 8'($urandom), 1'b0, 1'b0);
    do_reset();

    // Completer error on the TXDATA write.
    run_xfer(8'($urandom), 0, 0, 8'($urandom), 1'b0, 1'b1);
    do_reset();

    // Reset in the ACCESS phase of a STATUS poll.
    cfg_empty  = 100;
    cfg_wait   = 3;
    cfg_err_tx = 1'b0;
    stat_base  = stat_total;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    req_valid = 1'b1;
    req_data  = 8'($urandom);
    @(negedge PCLK);
    req_valid = 1'b0;
    cyc = 0;
    while (!(PSEL && PENABLE && PADDR == A_STAT) && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
    end
    check("poll_access_reached", {PSEL, PENABLE, PADDR}, {1'b1, 1'b1, A_STAT});
    do_reset();

    // Normal operation after recovery.
    run_xfer(8'($urandom), 1, 1, 8'($urandom), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_apb_sequencer.md
SPI_APB_SEQUENCER -- requirements
Module: spi_apb_sequencer

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 1023, max status polls per byte before timeout.
REQ-002 SHALL have parameter SSEL_MASK, default 8'h01, value written to the slave-select register at init.
REQ-003 SHALL have parameter CTRL_INIT, default 32'h0000_0003, value written to the control register at init (enable, master).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 PCLK  in  1  sole clock, rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  byte transfer request.
REQ-008 req_data  in  8  byte to transmit.
REQ-009 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-010 rsp_valid  out  1  one-cycle pulse, rsp_data valid.
REQ-011 rsp_data  out  8  byte received during the transfer.
REQ-012 err  out  1  sticky; timeout or PSLVERR seen; cleared only by PRESET.
REQ-013 PADDR  out  7, PSEL out 1, PENABLE out 1, PWRITE out 1, PWDATA out 32: APB master request to the SPI controller.
REQ-014 PRDATA  in  32, PREADY in 1, PSLVERR in 1: APB completer response.

Function
REQ-015 SHALL use register offsets CTRL 0x00, RXDATA 0x08, TXDATA 0x0C, STATUS 0x20, SSEL 0x24; STATUS bit2 = RX empty.
REQ-016 Every APB access SHALL be SETUP (PSEL=1, PENABLE=0, one cycle) then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable across both phases.
REQ-017 PSEL SHALL deassert the cycle after PREADY=1 unless a back-to-back access begins its SETUP that cycle.
REQ-018 FSM states: INIT_CTRL, INIT_SSEL, IDLE, WR_TX, POLL, RD_RX, RESP, ERR.
REQ-019 INIT_CTRL: write CTRL_INIT to CTRL -> INIT_SSEL: write {24'h0, SSEL_MASK} to SSEL -> IDLE.
REQ-020 IDLE: req_ready=1; on handshake capture req_data -> WR_TX; req_ready=0 in all other states.
REQ-021 WR_TX: write {24'h0, byte} to TXDATA -> POLL.
REQ-022 POLL: read STATUS; if PRDATA[2]=0 -> RD_RX, else re-read; poll counter increments per completed read.
REQ-023 Poll counter reaching POLL_LIMIT completed reads with RX still empty SHALL go to ERR.
REQ-024 RD_RX: read RXDATA; capture PRDATA[7:0] into rsp_data -> RESP.
REQ-025 RESP: rsp_valid=1 for exactly one cycle -> IDLE; rsp_data holds until next capture.
REQ-026 PSLVERR=1 on any completing access SHALL set err and go to ERR.
REQ-027 ERR: bus idle, req_ready=0, err=1, terminal until PRESET.
REQ-028 Poll counter width SHALL be clog2(POLL_LIMIT+1); reset to 0 on each WR_TX entry; no wrap.
REQ-029 Minimum latency with PREADY tied high and first poll non-empty: accept-to-rsp_valid 7 cycles (WR 2, POLL 2, RD 2, RESP 1).
REQ-030 req_valid while not ready SHALL be ignored; no request buffering.

Reset
REQ-031 PRESET=1 at any cycle, including mid-APB-access, SHALL force next state INIT_CTRL, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_data=0, err=0, poll counter 0.
REQ-032 Init sequence SHALL re-run after every reset release.

Structure
REQ-033 Register offsets, STATUS bit index and state enum SHALL live in shared package spi_apb_pkg.
REQ-034 One sub-module apb_master_if SHALL implement the SETUP/ACCESS handshake with start/write/addr/wdata in and done/rdata/slverr out.

Verification
REQ-035 Reset release, PREADY=1 -> writes CTRL=0x3 then SSEL=0x01, then req_ready=1.
REQ-036 req_data=0xA5, completer returns STATUS=0x0 then RXDATA=0x5A -> TXDATA write 0xA5, rsp_valid pulse with rsp_data=0x5A, 7 cycles after accept.
REQ-037 STATUS RX-empty for 3 polls, PREADY low 2 cycles per access -> 4 STATUS reads, signals stable during wait, correct rsp_data.
REQ-038 POLL_LIMIT=4, STATUS always 0x4 -> exactly 4 STATUS reads, err=1, req_ready stays 0.
REQ-039 PSLVERR=1 on TXDATA write -> err=1, no STATUS read issued.
REQ-040 PRESET asserted during POLL ACCESS phase -> PSEL=0 next cycle, err=0, init sequence repeats.
